// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared width helpers for queue controllers that sit in front of a
// register-file storage block. Reused by neighbouring queue blocks so that
// every controller sizes its address and occupancy fields the same way.
//   addr_width(n)  : storage address width for an n-entry file (min 1 bit)
//   count_width(n) : occupancy width, wide enough for n+1 entries, which
//                    covers the optional registered head stage

package fifo_ctrl_pkg;

    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if
// Bundles the push/pop streaming handshake, the register-file port and the
// occupancy output of fifo_ctrl.
//   modport slave  : the FIFO controller side
//   modport master : the surrounding pipeline / storage side
// Parameters DataWidth and NumEntries must match the attached fifo_ctrl.

interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int DataWidth  = 8,
    parameter int NumEntries = 4
);

    localparam int AddressWidth = addr_width(NumEntries);
    localparam int CountWidth   = count_width(NumEntries);

    logic                    push_valid_i;
    logic [DataWidth-1:0]    push_data_i;
    logic                    push_ready_o;

    logic                    pop_valid_o;
    logic [DataWidth-1:0]    pop_data_o;
    logic                    pop_ready_i;

    logic                    rf_wen_o;
    logic [AddressWidth-1:0] rf_waddr_o;
    logic [DataWidth-1:0]    rf_wdata_o;
    logic [AddressWidth-1:0] rf_raddr_o;
    logic [DataWidth-1:0]    rf_rdata_i;

    logic [CountWidth-1:0]   count_o;

    modport slave (
        input  push_valid_i, push_data_i, pop_ready_i, rf_rdata_i,
        output push_ready_o, pop_valid_o, pop_data_o,
               rf_wen_o, rf_waddr_o, rf_wdata_o, rf_raddr_o, count_o
    );

    modport master (
        output push_valid_i, push_data_i, pop_ready_i, rf_rdata_i,
        input  push_ready_o, pop_valid_o, pop_data_o,
               rf_wen_o, rf_waddr_o, rf_wdata_o, rf_raddr_o, count_o
    );

endinterface

// File: rtl/fifo_ctrl_ptr.sv
// fifo_ptr
// Wrap-aware storage pointer. Advances by one on incr and wraps from
// NumEntries-1 back to 0 explicitly, so non-power-of-two depths work.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, pointer returns to 0
//   incr : advance pointer this cycle
//   ptr  : current pointer value

module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int NumEntries = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              incr,
    output logic [addr_width(NumEntries)-1:0] ptr
);

    localparam int AddressWidth = addr_width(NumEntries);
    localparam logic [AddressWidth-1:0] LastIdx = AddressWidth'(NumEntries - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (incr) begin
            ptr <= (ptr == LastIdx) ? '0 : ptr + AddressWidth'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
// Synchronous FIFO controller that turns an external flat register file into
// a valid/ready queue. Pointers, occupancy and flags live here; the data lives
// in the register file instanced by the parent.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (contents discarded, storage stale)
//   bus : fifo_ctrl_if.slave
//         push_valid_i/push_data_i/push_ready_o : producer handshake
//         pop_valid_o/pop_data_o/pop_ready_i    : consumer handshake
//         rf_wen_o/rf_waddr_o/rf_wdata_o        : storage write port
//         rf_raddr_o/rf_rdata_i                 : storage read port (comb. data)
//         count_o                               : current occupancy
// Build option FIFO_CTRL_OUTREG_EN: adds a registered head stage after the
// storage; capacity grows to NumEntries+1 and empty-FIFO latency to 2 cycles.

module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DataWidth  = 8,
    parameter int NumEntries = 4
) (
    input  logic        clk,
    input  logic        rst,
    fifo_ctrl_if.slave  bus
);

    localparam int AddressWidth = addr_width(NumEntries);
    localparam int CountWidth   = count_width(NumEntries);

    logic [AddressWidth-1:0] wr_ptr;
    logic [AddressWidth-1:0] rd_ptr;
    logic [CountWidth-1:0]   st_count_q;
    logic                    st_full;
    logic                    st_empty;
    logic                    push_fire;
    logic                    pop_fire;
    logic                    rd_incr;
    logic [DataWidth-1:0]    head_data;

    // Occupancy of the register file itself (excludes any head stage).
    assign st_full  = (st_count_q == CountWidth'(NumEntries));
    assign st_empty = (st_count_q == '0);

    // Ready depends only on registered occupancy; write is blocked in reset.
    assign bus.push_ready_o = !st_full;
    assign push_fire        = bus.push_valid_i && !st_full && !rst;

    assign bus.rf_wen_o   = push_fire;
    assign bus.rf_waddr_o = wr_ptr;
    assign bus.rf_wdata_o = bus.push_data_i;
    assign bus.rf_raddr_o = rd_ptr;

`ifdef FIFO_CTRL_OUTREG_EN
    logic                 stage_vld_q;
    logic [DataWidth-1:0] stage_data_q;

    assign bus.pop_valid_o = stage_vld_q;
    assign pop_fire        = stage_vld_q && bus.pop_ready_i;
    // Refill whenever the stage is free this cycle and storage has an entry;
    // this keeps back-to-back pops at one per cycle.
    assign rd_incr         = !st_empty && (!stage_vld_q || pop_fire);
    assign head_data       = stage_data_q;
    assign bus.count_o     = st_count_q + CountWidth'(stage_vld_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= 1'b0;
        end else if (rd_incr) begin
            stage_vld_q <= 1'b1;
        end else if (pop_fire) begin
            stage_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_incr) begin
            stage_data_q <= bus.rf_rdata_i;
        end
    end
`else
    assign bus.pop_valid_o = !st_empty;
    assign pop_fire        = !st_empty && bus.pop_ready_i;
    assign rd_incr         = pop_fire;
    assign head_data       = bus.rf_rdata_i;
    assign bus.count_o     = st_count_q;
`endif

    assign bus.pop_data_o = head_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_count_q <= '0;
        end else begin
            case ({push_fire, rd_incr})
                2'b10:   st_count_q <= st_count_q + CountWidth'(1);
                2'b01:   st_count_q <= st_count_q - CountWidth'(1);
                default: st_count_q <= st_count_q;
            endcase
        end
    end

    fifo_ptr #(.NumEntries(NumEntries)) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .incr (push_fire),
        .ptr  (wr_ptr)
    );

    fifo_ptr #(.NumEntries(NumEntries)) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .incr (rd_incr),
        .ptr  (rd_ptr)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.DataWidth(8), .NumEntries(4)) a ();
    fifo_ctrl_if #(.DataWidth(8), .NumEntries(3)) b ();

    fifo_ctrl #(.DataWidth(8), .NumEntries(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
    fifo_ctrl #(.DataWidth(8), .NumEntries(3)) dut_b (.clk(clk), .rst(rst), .bus(b));

    // Storage register files owned by the parent (here: the bench).
    logic [7:0] rf_a [4];
    logic [7:0] rf_b [3];

    always @(posedge clk) begin
        if (a.rf_wen_o) rf_a[a.rf_waddr_o] <= a.rf_wdata_o;
        if (b.rf_wen_o && b.rf_waddr_o < 2'd3) rf_b[b.rf_waddr_o] <= b.rf_wdata_o;
    end
    assign a.rf_rdata_i = rf_a[a.rf_raddr_o];
    assign b.rf_rdata_i = (b.rf_raddr_o < 2'd3) ? rf_b[b.rf_raddr_o] : 8'h00;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: ordered queue of held items ----------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit stg  [2] = '{1'b0, 1'b0};
    int wcnt [2] = '{0, 0};
    int rcnt [2] = '{0, 0};
    int dep  [2] = '{4, 3};

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction
    function automatic logic [7:0] q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction
    function automatic void q_pop(input int k);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endfunction
    function automatic void q_push(input int k, input logic [7:0] d);
        if (k == 0) q0.push_back(d); else q1.push_back(d);
    endfunction
    function automatic void q_clear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endfunction

    // Items sitting in the register file (the head stage, if any, is excluded).
    function automatic int store_sz(input int k);
`ifdef FIFO_CTRL_OUTREG_EN
        return q_size(k) - int'(stg[k]);
`else
        return q_size(k);
`endif
    endfunction
    function automatic bit exp_ready(input int k);
        return store_sz(k) < dep[k];
    endfunction
    function automatic bit exp_valid(input int k);
`ifdef FIFO_CTRL_OUTREG_EN
        return stg[k];
`else
        return q_size(k) > 0;
`endif
    endfunction

    task automatic model_step(input int k, input logic r, input logic pv,
                              input logic [7:0] pd, input logic pr);
        bit pushf, popf, refill;
        int st;
        if (r) begin
            q_clear(k);
            stg[k]  = 1'b0;
            wcnt[k] = 0;
            rcnt[k] = 0;
        end else begin
            st     = store_sz(k);
            pushf  = pv && exp_ready(k);
            popf   = exp_valid(k) && pr;
`ifdef FIFO_CTRL_OUTREG_EN
            refill = (!stg[k] || popf) && st > 0;
            stg[k] = refill ? 1'b1 : (popf ? 1'b0 : stg[k]);
            if (refill) rcnt[k]++;
`else
            refill = popf;
            if (refill) rcnt[k]++;
`endif
            if (popf) q_pop(k);
            if (pushf) begin
                q_push(k, pd);
                wcnt[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst, a.push_valid_i, a.push_data_i, a.pop_ready_i);
        model_step(1, rst, b.push_valid_i, b.push_data_i, b.pop_ready_i);
    end

    task automatic compare_inst(input int k, input logic [31:0] cnt, input logic rdy,
                                input logic vld, input logic [31:0] dat, input logic wen,
                                input logic [31:0] wa, input logic [31:0] wd,
                                input logic [31:0] ra, input logic pv, input logic [31:0] pd);
        string p;
        bit    ewen;
        p    = (k == 0) ? "a" : "b";
        ewen = pv && exp_ready(k) && !rst;
        check({p, ".count"}, cnt, q_size(k));
        check({p, ".push_ready"}, {31'd0, rdy}, {31'd0, exp_ready(k)});
        check({p, ".pop_valid"}, {31'd0, vld}, {31'd0, exp_valid(k)});
        if (exp_valid(k)) check({p, ".pop_data"}, dat, {24'd0, q_front(k)});
        check({p, ".rf_wen"}, {31'd0, wen}, {31'd0, ewen});
        if (ewen) begin
            check({p, ".rf_waddr"}, wa, wcnt[k] % dep[k]);
            check({p, ".rf_wdata"}, wd, pd);
        end
        check({p, ".rf_raddr"}, ra, rcnt[k] % dep[k]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_inst(0, a.count_o, a.push_ready_o, a.pop_valid_o, a.pop_data_o,
                         a.rf_wen_o, a.rf_waddr_o, a.rf_wdata_o, a.rf_raddr_o,
                         a.push_valid_i, a.push_data_i);
            compare_inst(1, b.count_o, b.push_ready_o, b.pop_valid_o, b.pop_data_o,
                         b.rf_wen_o, b.rf_waddr_o, b.rf_wdata_o, b.rf_raddr_o,
                         b.push_valid_i, b.push_data_i);
        end
    end

    // ---------------- directed stimulus with literal expectations -------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int npop;
        a.push_valid_i = 1'b0; a.push_data_i = 8'h00; a.pop_ready_i = 1'b0;
        b.push_valid_i = 1'b0; b.push_data_i = 8'h00; b.pop_ready_i = 1'b0;

        // Reset for two cycles; a push presented during reset must not write.
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        a.push_valid_i = 1'b1; a.push_data_i = 8'h99;
        #1;
        check("rst_wen_gated", {31'd0, a.rf_wen_o}, 32'd0);
        tick();
        rst = 1'b0;
        a.push_valid_i = 1'b0;
        #1;
        check("rst_count", a.count_o, 32'd0);
        check("rst_pop_valid", {31'd0, a.pop_valid_o}, 32'd0);
        check("rst_push_ready", {31'd0, a.push_ready_o}, 32'd1);
        check("rst_wen", {31'd0, a.rf_wen_o}, 32'd0);

        // Fill to full, then offer a fifth push.
        for (int i = 0; i < 4; i++) begin
            a.push_valid_i = 1'b1;
            a.push_data_i  = 8'(17 * (i + 1));
            tick();
        end
        a.push_data_i = 8'h55;
        #1;
`ifndef FIFO_CTRL_OUTREG_EN
        check("fill_count", a.count_o, 32'd4);
        check("fill_push_ready", {31'd0, a.push_ready_o}, 32'd0);
        check("fifth_wen", {31'd0, a.rf_wen_o}, 32'd0);
`endif
        tick();
        a.push_valid_i = 1'b0;
`ifndef FIFO_CTRL_OUTREG_EN
        check("fifth_not_written", {24'd0, rf_a[0]}, 32'h11);
`endif

        // Drain in order.
        a.pop_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifndef FIFO_CTRL_OUTREG_EN
            check("drain_valid", {31'd0, a.pop_valid_o}, 32'd1);
            check("drain_data", a.pop_data_o, 17 * (i + 1));
`endif
            tick();
        end
        #1;
`ifndef FIFO_CTRL_OUTREG_EN
        check("drain_end_valid", {31'd0, a.pop_valid_o}, 32'd0);
        check("drain_end_count", a.count_o, 32'd0);
`endif
        a.pop_ready_i = 1'b0;

        // Depth-3 wrap: interleaved push/pop, addresses 0,1,2,0,...
        npop = 0;
        b.pop_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b.push_valid_i = (i < 10);
            b.push_data_i  = 8'(8'hB0 + i);
            #1;
            if (i < 10) begin
                check("wrap_wen", {31'd0, b.rf_wen_o}, 32'd1);
                check("wrap_waddr", b.rf_waddr_o, i % 3);
            end
            if (b.pop_valid_o) begin
                check("wrap_data", b.pop_data_o, 32'hB0 + npop);
`ifndef FIFO_CTRL_OUTREG_EN
                check("wrap_raddr", b.rf_raddr_o, npop % 3);
`endif
                npop++;
            end
            tick();
        end
        check("wrap_pop_total", npop, 32'd10);
        b.push_valid_i = 1'b0;
        b.pop_ready_i  = 1'b0;

        // Simultaneous push/pop at count 2.
        a.push_valid_i = 1'b1; a.push_data_i = 8'h01;
        tick();
        a.push_data_i = 8'h02;
        tick();
        a.push_data_i = 8'hAA;
        a.pop_ready_i = 1'b1;
        #1;
`ifndef FIFO_CTRL_OUTREG_EN
        check("sim_count_before", a.count_o, 32'd2);
        check("sim_wen", {31'd0, a.rf_wen_o}, 32'd1);
        check("sim_waddr", a.rf_waddr_o, 32'd2);
        check("sim_head", a.pop_data_o, 32'h01);
`endif
        tick();
        a.push_valid_i = 1'b0;
        a.pop_ready_i  = 1'b0;
        #1;
`ifndef FIFO_CTRL_OUTREG_EN
        check("sim_count_after", a.count_o, 32'd2);
        check("sim_head_after", a.pop_data_o, 32'h02);
        check("sim_aa_stored", {24'd0, rf_a[2]}, 32'hAA);
`endif

        // Reset mid-operation at count 3.
        a.push_valid_i = 1'b1; a.push_data_i = 8'h03;
        tick();
        a.push_valid_i = 1'b0;
        #1;
`ifndef FIFO_CTRL_OUTREG_EN
        check("pre_rst_count", a.count_o, 32'd3);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_count", a.count_o, 32'd0);
        check("mid_rst_valid", {31'd0, a.pop_valid_o}, 32'd0);
        a.pop_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale_pop", {31'd0, a.pop_valid_o}, 32'd0);
        end
        a.pop_ready_i = 1'b0;

        // Push latency into an empty FIFO, then capacity.
        a.push_valid_i = 1'b1; a.push_data_i = 8'h5A;
        tick();
        a.push_valid_i = 1'b0;
        #1;
`ifdef FIFO_CTRL_OUTREG_EN
        check("lat_valid_n1", {31'd0, a.pop_valid_o}, 32'd0);
        tick();
        check("lat_valid_n2", {31'd0, a.pop_valid_o}, 32'd1);
        check("lat_data", a.pop_data_o, 32'h5A);
        for (int i = 0; i < 4; i++) begin
            a.push_valid_i = 1'b1; a.push_data_i = 8'(8'h60 + i);
            tick();
        end
        a.push_data_i = 8'h70;
        #1;
        check("cap_count", a.count_o, 32'd5);
        check("cap_push_ready", {31'd0, a.push_ready_o}, 32'd0);
        check("cap_wen", {31'd0, a.rf_wen_o}, 32'd0);
`else
        check("lat_valid_n1", {31'd0, a.pop_valid_o}, 32'd1);
        check("lat_data", a.pop_data_o, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            a.push_valid_i = 1'b1; a.push_data_i = 8'(8'h60 + i);
            tick();
        end
        a.push_data_i = 8'h70;
        #1;
        check("cap_count", a.count_o, 32'd4);
        check("cap_push_ready", {31'd0, a.push_ready_o}, 32'd0);
        check("cap_wen", {31'd0, a.rf_wen_o}, 32'd0);
`endif
        tick();
        a.push_valid_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
